// File: rtl/cabac_byte_writer.sv
// cabac_byte_writer
// Byte-output stage of the CABAC arithmetic encoder. Accepts 9-bit lead
// bytes (bit 8 = carry) from the low-register normaliser, holds back runs
// of 0xFF bytes until the carry that may ripple through them is known, and
// emits the finished bitstream bytes over a valid/ready interface. A flush
// request drains everything still buffered at slice end.
//
// Optional feature macro: CABAC_BYTE_WRITER_CNT_EN
//    When defined, adds a 32-bit output byte counter port byte_cnt.

module cabac_byte_writer #(
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] lead_byte,
   input  logic       lead_valid,
   output logic       lead_ready,
   input  logic       flush,
   input  logic       flush_carry,
   output logic       flush_done,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       busy
`ifdef CABAC_BYTE_WRITER_CNT_EN
   ,
   output logic [31:0] byte_cnt
`endif
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_EMIT_BUF = 2'd1;
   localparam logic [1:0] S_EMIT_RUN = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   localparam logic [CNT_W-1:0] NUM_MAX  = '1;
   localparam logic [CNT_W-1:0] NUM_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] NUM_ZERO = '0;

   logic [1:0]       r_state;
   logic [7:0]       r_buf_byte;
   logic [CNT_W-1:0] r_num_buf;
   logic [CNT_W-1:0] r_run_cnt;
   logic [7:0]       r_run_byte;
   logic [7:0]       r_byte_out;
   logic             r_byte_valid;
   logic             r_flushing;

   logic             w_lead_ready;
   logic             w_accept;
   logic             w_handshake;
   logic             w_carry;
   logic [7:0]       w_pending;
   logic [7:0]       w_run_fill;

   // The buffered byte can only be released once the next non-0xFF lead
   // byte (or the final flush carry) tells us whether a carry ripples in.
   assign w_lead_ready = (r_state == S_IDLE) && !flush && (r_num_buf != NUM_MAX);
   assign w_accept     = lead_valid && w_lead_ready;
   assign w_handshake  = r_byte_valid && byte_ready;
   assign w_carry      = flush ? flush_carry : lead_byte[8];
   assign w_pending    = r_buf_byte + {7'd0, w_carry};
   assign w_run_fill   = w_carry ? 8'h00 : 8'hFF;

   assign lead_ready = w_lead_ready;
   assign flush_done = (r_state == S_DONE);
   assign byte_out   = r_byte_out;
   assign byte_valid = r_byte_valid;
   assign busy       = (r_state != S_IDLE);

   // Main FSM: buffer lead bytes in IDLE, then stream the resolved buffered
   // byte followed by the run of 0xFF (or 0x00 after a carry) bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_buf_byte   <= 8'hFF;
         r_num_buf    <= NUM_ZERO;
         r_run_cnt    <= NUM_ZERO;
         r_run_byte   <= 8'hFF;
         r_byte_out   <= 8'h00;
         r_byte_valid <= 1'b0;
         r_flushing   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (flush) begin
                  if (r_num_buf == NUM_ZERO) begin
                     r_state <= S_DONE;
                  end else begin
                     r_byte_out   <= w_pending;
                     r_byte_valid <= 1'b1;
                     r_run_byte   <= w_run_fill;
                     r_run_cnt    <= r_num_buf - NUM_ONE;
                     r_flushing   <= 1'b1;
                     r_state      <= S_EMIT_BUF;
                  end
               end else if (w_accept) begin
                  if (lead_byte == 9'h0FF) begin
                     r_num_buf <= r_num_buf + NUM_ONE;
                  end else if (r_num_buf != NUM_ZERO) begin
                     r_byte_out   <= w_pending;
                     r_byte_valid <= 1'b1;
                     r_run_byte   <= w_run_fill;
                     r_run_cnt    <= r_num_buf - NUM_ONE;
                     r_buf_byte   <= lead_byte[7:0];
                     r_num_buf    <= NUM_ONE;
                     r_state      <= S_EMIT_BUF;
                  end else begin
                     r_buf_byte <= lead_byte[7:0];
                     r_num_buf  <= NUM_ONE;
                  end
               end
            end
            S_EMIT_BUF: begin
               if (w_handshake) begin
                  if (r_run_cnt != NUM_ZERO) begin
                     r_byte_out <= r_run_byte;
                     r_state    <= S_EMIT_RUN;
                  end else begin
                     r_byte_valid <= 1'b0;
                     r_state      <= r_flushing ? S_DONE : S_IDLE;
                  end
               end
            end
            S_EMIT_RUN: begin
               if (w_handshake) begin
                  r_run_cnt <= r_run_cnt - NUM_ONE;
                  if (r_run_cnt == NUM_ONE) begin
                     r_byte_valid <= 1'b0;
                     r_state      <= r_flushing ? S_DONE : S_IDLE;
                  end
               end
            end
            default: begin
               r_num_buf  <= NUM_ZERO;
               r_buf_byte <= 8'hFF;
               r_flushing <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CABAC_BYTE_WRITER_CNT_EN
   logic [31:0] r_byte_cnt;

   // Count delivered bytes per slice; cleared as the drain completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_cnt <= 32'd0;
      end else if (r_state == S_DONE) begin
         r_byte_cnt <= 32'd0;
      end else if (w_handshake) begin
         r_byte_cnt <= r_byte_cnt + 32'd1;
      end
   end

   assign byte_cnt = r_byte_cnt;
`endif

endmodule

// File: tb/tb_cabac_byte_writer.sv
// tb_cabac_byte_writer
// Directed bench for cabac_byte_writer: a default-width instance for the
// main byte/run/flush scenarios and a CNT_W=2 instance for saturation.

module tb_cabac_byte_writer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] leadByte;
   logic       leadValid;
   logic       leadReady;
   logic       flush;
   logic       flushCarry;
   logic       flushDone;
   logic [7:0] byteOut;
   logic       byteValid;
   logic       byteReady;
   logic       busy;

   logic [8:0] leadByte2;
   logic       leadValid2;
   logic       leadReady2;
   logic       flushDone2;
   logic [7:0] byteOut2;
   logic       byteValid2;
   logic       busy2;

`ifdef CABAC_BYTE_WRITER_CNT_EN
   logic [31:0] byteCnt;
   logic [31:0] byteCnt2;
`endif

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   int doneCount = 0;
   int leadViol = 0;
   int stabViol = 0;
   int holdCount = 0;
   logic holdPrev = 1'b0;
   logic [7:0] heldByte = 8'h00;
   logic toggleEn = 1'b0;
   logic [7:0] outBytes[$];
   int outCycles[$];

   cabac_byte_writer dut (
      .clk(clk), .rst_n(rst_n),
      .lead_byte(leadByte), .lead_valid(leadValid), .lead_ready(leadReady),
      .flush(flush), .flush_carry(flushCarry), .flush_done(flushDone),
      .byte_out(byteOut), .byte_valid(byteValid), .byte_ready(byteReady),
      .busy(busy)
`ifdef CABAC_BYTE_WRITER_CNT_EN
      , .byte_cnt(byteCnt)
`endif
   );

   cabac_byte_writer #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .lead_byte(leadByte2), .lead_valid(leadValid2), .lead_ready(leadReady2),
      .flush(1'b0), .flush_carry(1'b0), .flush_done(flushDone2),
      .byte_out(byteOut2), .byte_valid(byteValid2), .byte_ready(1'b1),
      .busy(busy2)
`ifdef CABAC_BYTE_WRITER_CNT_EN
      , .byte_cnt(byteCnt2)
`endif
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Cycle stamp used to confirm back-to-back output bytes.
   always @(posedge clk) cycle++;

   // Toggle byte_ready every cycle while back-pressure is enabled.
   always @(posedge clk) begin
      if (toggleEn) begin
         #1;
         byteReady = ~byteReady;
      end
   end

   // Observe the output side mid-cycle: capture handshakes, count
   // flush_done pulses, and watch stability and lead_ready during emission.
   always @(negedge clk) begin
      if (rst_n) begin
         if (byteValid && byteReady) begin
            outBytes.push_back(byteOut);
            outCycles.push_back(cycle);
         end
         if (flushDone) doneCount++;
         if (busy && leadReady) leadViol++;
         if (holdPrev && (!byteValid || byteOut !== heldByte)) stabViol++;
         holdPrev = byteValid && !byteReady;
         if (holdPrev) holdCount++;
         heldByte = byteOut;
      end else begin
         holdPrev = 1'b0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present one lead byte and hold it until accepted.
   task automatic sendLead(input logic [8:0] b);
      int n;
      n = 0;
      leadByte = b;
      leadValid = 1'b1;
      @(negedge clk);
      while (!leadReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("[TB] FAIL lead_accept_timeout byte=%h lead_ready=%b required=1", b, leadReady);
      end
      tick();
      leadValid = 1'b0;
   endtask

   // Hold flush until flush_done, then drop it.
   task automatic doFlush(input logic c);
      int n;
      n = 0;
      flush = 1'b1;
      flushCarry = c;
      @(negedge clk);
      while (!flushDone && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("[TB] FAIL flush_done_timeout flush_done=%b required=1", flushDone);
      end
      tick();
      flush = 1'b0;
      flushCarry = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("[TB] FAIL %s_idle_timeout busy=%b required=0", name, busy);
      end
      tick();
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      checks++;
      if (byteValid !== 1'b0 || busy !== 1'b0 || flushDone !== 1'b0 || byteOut !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_outputs valid=%b busy=%b done=%b out=%h required 0 0 0 00",
                  byteValid, busy, flushDone, byteOut);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (leadReady !== 1'b1 || leadReady2 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_lead_ready got=%b/%b required=1/1", leadReady, leadReady2);
      end
   endtask

   task automatic test_single_byte;
      logic [7:0] exp[2] = '{8'h12, 8'h34};
      int d0;
      outBytes.delete();
      outCycles.delete();
      sendLead(9'h012);
      sendLead(9'h034);
      waitIdle("single");
      checks++;
      if (outBytes.size() !== 1) begin
         errors++;
         $display("[TB] FAIL single_count got=%0d required=1", outBytes.size());
      end else if (outBytes[0] !== exp[0]) begin
         checks++;
         errors++;
         $display("[TB] FAIL single_byte got=%h required=%h", outBytes[0], exp[0]);
      end
      d0 = doneCount;
      doFlush(1'b0);
      checks++;
      if (outBytes.size() !== 2 || outBytes[outBytes.size()-1] !== exp[1]) begin
         errors++;
         $display("[TB] FAIL single_flush_buf count=%0d last=%h required 2/%h",
                  outBytes.size(), outBytes[outBytes.size()-1], exp[1]);
      end
      tick();
      checks++;
      if (doneCount - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL single_done_pulses got=%0d required=1", doneCount - d0);
      end
   endtask

   task automatic test_run_no_carry;
      logic [7:0] exp[3] = '{8'h12, 8'hFF, 8'hFF};
      outBytes.delete();
      outCycles.delete();
      sendLead(9'h012);
      sendLead(9'h0FF);
      sendLead(9'h0FF);
      sendLead(9'h034);
      waitIdle("run");
      checks++;
      if (outBytes.size() !== 3) begin
         errors++;
         $display("[TB] FAIL run_count got=%0d required=3", outBytes.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (outBytes[i] !== exp[i]) begin
               errors++;
               $display("[TB] FAIL run_byte%0d got=%h required=%h", i, outBytes[i], exp[i]);
            end
         end
         checks++;
         if (outCycles[1] !== outCycles[0] + 1 || outCycles[2] !== outCycles[1] + 1) begin
            errors++;
            $display("[TB] FAIL run_back_to_back cycles=%0d,%0d,%0d required consecutive",
                     outCycles[0], outCycles[1], outCycles[2]);
         end
      end
      checks++;
      if (busy !== 1'b0 || leadReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL run_idle busy=%b lead_ready=%b required 0/1", busy, leadReady);
      end
      doFlush(1'b0);
      checks++;
      if (outBytes.size() !== 4 || outBytes[3] !== 8'h34) begin
         errors++;
         $display("[TB] FAIL run_flush_buf count=%0d required 4 with last 34", outBytes.size());
      end
   endtask

   task automatic test_run_carry(input string name, input logic bp);
      logic [7:0] exp[3] = '{8'h13, 8'h00, 8'h00};
      int s0;
      int h0;
      int l0;
      outBytes.delete();
      outCycles.delete();
      s0 = stabViol;
      h0 = holdCount;
      l0 = leadViol;
      if (bp) toggleEn = 1'b1;
      sendLead(9'h012);
      sendLead(9'h0FF);
      sendLead(9'h0FF);
      sendLead(9'h134);
      waitIdle(name);
      toggleEn = 1'b0;
      tick();
      byteReady = 1'b1;
      checks++;
      if (outBytes.size() !== 3) begin
         errors++;
         $display("[TB] FAIL %s_count got=%0d required=3", name, outBytes.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (outBytes[i] !== exp[i]) begin
               errors++;
               $display("[TB] FAIL %s_byte%0d got=%h required=%h", name, i, outBytes[i], exp[i]);
            end
         end
      end
      if (bp) begin
         checks++;
         if (stabViol - s0 !== 0 || holdCount - h0 < 1) begin
            errors++;
            $display("[TB] FAIL %s_stability violations=%0d holds=%0d required 0 and >0",
                     name, stabViol - s0, holdCount - h0);
         end
         checks++;
         if (leadViol - l0 !== 0) begin
            errors++;
            $display("[TB] FAIL %s_lead_ready_busy got=%0d required=0", name, leadViol - l0);
         end
      end
      doFlush(1'b0);
      checks++;
      if (outBytes.size() !== 4 || outBytes[3] !== 8'h34) begin
         errors++;
         $display("[TB] FAIL %s_flush_buf count=%0d required 4 with last 34", name, outBytes.size());
      end
   endtask

   task automatic test_flush;
      int d0;
      outBytes.delete();
      sendLead(9'h0AB);
      sendLead(9'h0FF);
      d0 = doneCount;
      doFlush(1'b1);
      tick();
      checks++;
      if (outBytes.size() !== 2) begin
         errors++;
         $display("[TB] FAIL flush_count got=%0d required=2", outBytes.size());
      end else begin
         checks++;
         if (outBytes[0] !== 8'hAC || outBytes[1] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL flush_bytes got=%h,%h required=ac,00", outBytes[0], outBytes[1]);
         end
      end
      checks++;
      if (doneCount - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL flush_done_pulses got=%0d required=1", doneCount - d0);
      end
      outBytes.delete();
      d0 = doneCount;
      doFlush(1'b0);
      tick();
      checks++;
      if (outBytes.size() !== 0 || doneCount - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL flush_empty bytes=%0d pulses=%0d required 0/1",
                  outBytes.size(), doneCount - d0);
      end
   endtask

   task automatic test_saturation;
      leadByte2 = 9'h012;
      leadValid2 = 1'b1;
      tick();
      checks++;
      if (leadReady2 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_num1 lead_ready=%b required=1", leadReady2);
      end
      leadByte2 = 9'h0FF;
      tick();
      checks++;
      if (leadReady2 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_num2 lead_ready=%b required=1", leadReady2);
      end
      tick();
      checks++;
      if (leadReady2 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sat_num3 lead_ready=%b required=0", leadReady2);
      end
      tick();
      tick();
      checks++;
      if (leadReady2 !== 1'b0 || busy2 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sat_hold lead_ready=%b busy=%b required 0/0", leadReady2, busy2);
      end
      leadValid2 = 1'b0;
   endtask

   task automatic test_reset_mid_run;
      int d0;
      byteReady = 1'b0;
      sendLead(9'h012);
      sendLead(9'h0FF);
      sendLead(9'h0FF);
      sendLead(9'h034);
      byteReady = 1'b1;
      tick();
      byteReady = 1'b0;
      tick();
      checks++;
      if (byteValid !== 1'b1 || byteOut !== 8'hFF || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrun_setup valid=%b out=%h busy=%b required 1/ff/1",
                  byteValid, byteOut, busy);
      end
      #3;
      rst_n = 1'b0;
      #2;
      checks++;
      if (byteValid !== 1'b0 || busy !== 1'b0 || byteOut !== 8'h00 || leadReady2 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrun_reset valid=%b busy=%b out=%h ready2=%b required 0/0/00/1",
                  byteValid, busy, byteOut, leadReady2);
      end
      tick();
      rst_n = 1'b1;
      byteReady = 1'b1;
      tick();
      outBytes.delete();
      d0 = doneCount;
      doFlush(1'b0);
      tick();
      checks++;
      if (outBytes.size() !== 0 || doneCount - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL midrun_num_buf bytes=%0d pulses=%0d required 0/1",
                  outBytes.size(), doneCount - d0);
      end
      sendLead(9'h0FF);
      sendLead(9'h034);
      waitIdle("midrun");
      checks++;
      if (outBytes.size() !== 1 || outBytes[0] !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL midrun_buf_reset count=%0d required 1 byte ff", outBytes.size());
      end
   endtask

   // Run every scenario in sequence, then report.
   initial begin
      leadByte = 9'h000;
      leadValid = 1'b0;
      flush = 1'b0;
      flushCarry = 1'b0;
      byteReady = 1'b1;
      leadByte2 = 9'h000;
      leadValid2 = 1'b0;
      test_reset();
      test_single_byte();
      test_run_no_carry();
      test_run_carry("carry", 1'b0);
      test_run_carry("backpressure", 1'b1);
      test_flush();
      test_saturation();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cabac_byte_writer.md
Name: cabac_byte_writer

Overview:
Byte-output stage of the CABAC arithmetic encoder, and the encoder-side counterpart of the decoder's byte reader. It takes 9-bit lead bytes from the encoder's low-register normaliser, where bit 8 is the carry and bits 7:0 are the byte. It holds back runs of 0xFF bytes until the carry is resolved, then emits the finished bitstream bytes over a valid/ready interface. A flush command drains the buffered bytes at slice end.

Parameters:
CNT_W, 8, width of the outstanding-byte counter num_buf; the maximum number of buffered bytes is 2^CNT_W-1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lead_byte  in  9  [8]=carry, [7:0]=lead byte from the encoder
lead_valid  in  1  lead_byte is valid
lead_ready  out  1  block accepts lead_byte this cycle
flush  in  1  level; request end-of-slice drain; held high until flush_done
flush_carry  in  1  final carry from the encoder low register, sampled with flush
flush_done  out  1  one-cycle pulse when the drain is complete
byte_out  out  8  output bitstream byte
byte_valid  out  1  byte_out is valid
byte_ready  in  1  downstream accepts byte_out
busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, buf_byte=0xFF, num_buf=0, run_cnt=0, run_byte=0xFF, byte_out=0x00, byte_valid=0, flush_done=0, busy=0.
- lead_ready = (state==IDLE) && !flush && (num_buf != 2^CNT_W-1). This is combinational from registers and flush.
- The FSM has four states: IDLE, EMIT_BUF, EMIT_RUN, DONE.
- Accepting a byte in IDLE (lead_valid && lead_ready):
  - lead_byte == 9'h0FF: num_buf += 1. No output. Stay in IDLE.
  - Otherwise, if num_buf > 0:
    - The pending output byte is (buf_byte + lead_byte[8]) mod 256.
    - run_byte = lead_byte[8] ? 0x00 : 0xFF; run_cnt = num_buf-1.
    - buf_byte = lead_byte[7:0]; num_buf = 1.
    - Go to EMIT_BUF.
  - Otherwise (num_buf == 0): buf_byte = lead_byte[7:0]; num_buf = 1. A carry bit of 1 here is a protocol violation and is ignored. Stay in IDLE.
- Flush in IDLE (flush=1) takes priority over lead_valid; no lead byte is accepted in that cycle.
  - If num_buf == 0: go to DONE.
  - Else: the pending byte is (buf_byte + flush_carry) mod 256; run_byte = flush_carry ? 0x00 : 0xFF; run_cnt = num_buf-1; go to EMIT_BUF with the flush marker set.
- EMIT_BUF: byte_out and byte_valid are registered and are driven from the cycle after entry. On the byte_valid && byte_ready handshake:
  - If run_cnt > 0, go to EMIT_RUN.
  - Else go to DONE if flushing, otherwise to IDLE.
- EMIT_RUN: byte_out=run_byte. Each handshake decrements run_cnt. The handshake with run_cnt==1 leaves for DONE (if flushing) or IDLE.
  - Back-to-back bytes are produced when byte_ready is held high, giving 1 byte/cycle.
- Output stability: byte_out and byte_valid stay stable while byte_valid && !byte_ready. byte_valid never drops without a handshake.
- DONE: flush_done=1 for exactly one cycle. Set num_buf=0 and buf_byte=0xFF, go to IDLE. flush must be low in the cycle after flush_done, otherwise a new flush starts.
- num_buf saturates at 2^CNT_W-1 by back-pressure (lead_ready low); it never wraps.
- Asserting reset mid-emission aborts immediately to the reset values; pending bytes are lost.

Optional Feature:
CABAC_BYTE_WRITER_CNT_EN
- With the macro defined: adds output port byte_cnt [31:0]. It increments on every byte_valid && byte_ready, resets to 0 on rst_n, and clears on the cycle flush_done pulses. It wraps modulo 2^32.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
1. Single byte: send lead bytes 0x012 then 0x034 with byte_ready=1 -> exactly one output byte 0x12, buf_byte=0x34, num_buf=1.
2. 0xFF run without carry: send 0x012, 0x0FF, 0x0FF, 0x034 -> output 0x12, 0xFF, 0xFF on consecutive cycles, then the block is back in IDLE.
3. 0xFF run with carry: send 0x012, 0x0FF, 0x0FF, 0x134 -> output 0x13, 0x00, 0x00; buf_byte=0x34.
4. Back-pressure: repeat test 3 with byte_ready toggling 0/1 every cycle -> the same three bytes, each held stable while byte_ready=0, and lead_ready=0 throughout the emission.
5. Flush: after 0x0AB, 0x0FF, assert flush with flush_carry=1 -> output 0xAC, 0x00, then a single flush_done pulse, num_buf=0. With nothing buffered, flush -> flush_done with no output bytes.
6. Saturation and reset: with CNT_W=2, send 0x012 followed by 0x0FF -> lead_ready goes low once num_buf=3. Asserting rst_n=0 mid-EMIT_RUN -> byte_valid=0 immediately, and all registers return to their reset values.
